// File: rtl/four_csa_pkg.sv
// Shared constants for the four_csa carry-select adder.
package four_csa_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_BLOCK = 4;
    localparam int NBLK      = DEF_WIDTH / DEF_BLOCK;
endpackage

// File: rtl/four_csa_rca4.sv
// BLOCK-bit ripple-carry adder built from explicit full-adder bit slices.
module rca4 #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);
    logic [BLOCK:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < BLOCK; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co = c[BLOCK];
endmodule

// File: rtl/four_csa.sv
// Carry-select adder: block 0 ripples from Cin, upper blocks pick between
// speculative carry-0/carry-1 results; S/Cout also registered with async clear.
module four_csa
    import four_csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_r,
    output logic             Cout_r
);
    localparam int NUM_BLK = WIDTH / BLOCK;

    // carry[k] is the true carry entering block k
    logic [NUM_BLK:0] carry;

    assign carry[0] = Cin;

    for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
        if (gi == 0) begin : g_first
            rca4 #(.BLOCK(BLOCK)) u_rca (
                .a  (A[BLOCK-1:0]),
                .b  (B[BLOCK-1:0]),
                .ci (carry[0]),
                .s  (S[BLOCK-1:0]),
                .co (carry[1])
            );
        end else begin : g_sel
            logic [BLOCK-1:0] s0;
            logic [BLOCK-1:0] s1;
            logic             c0;
            logic             c1;

            rca4 #(.BLOCK(BLOCK)) u_rca0 (
                .a  (A[gi*BLOCK +: BLOCK]),
                .b  (B[gi*BLOCK +: BLOCK]),
                .ci (1'b0),
                .s  (s0),
                .co (c0)
            );
            rca4 #(.BLOCK(BLOCK)) u_rca1 (
                .a  (A[gi*BLOCK +: BLOCK]),
                .b  (B[gi*BLOCK +: BLOCK]),
                .ci (1'b1),
                .s  (s1),
                .co (c1)
            );

            assign S[gi*BLOCK +: BLOCK] = carry[gi] ? s1 : s0;
            assign carry[gi+1]          = c0 | (c1 & carry[gi]);
        end
    end

    assign Cout = carry[NUM_BLK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_r    <= '0;
            Cout_r <= 1'b0;
        end else begin
            S_r    <= S;
            Cout_r <= Cout;
        end
    end
endmodule

// File: tb/tb_four_csa.sv
// Directed and sweep checks for four_csa, combinational and registered paths.
module tb_four_csa;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Cin = 1'b0;
    logic [7:0] S;
    logic       Cout;
    logic [7:0] S_r;
    logic       Cout_r;

    int n_cmp = 0;
    int n_bad = 0;

    four_csa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .S      (S),
        .Cout   (Cout),
        .S_r    (S_r),
        .Cout_r (Cout_r)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c);
        A = a;
        B = b;
        Cin = c;
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_regs: got %h want 000", {Cout_r, S_r});
        end
        $display("reset: Cout_r=%b S_r=%h", Cout_r, S_r);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] ta [8] = '{8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'hA5, 8'h12, 8'h80};
        logic [7:0] tb [8] = '{8'h01, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h5A, 8'h34, 8'h80};
        logic       tc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0] te [8] = '{9'h010, 9'h100, 9'h1FF, 9'h001, 9'h100, 9'h0FF, 9'h046, 9'h100};
        for (int i = 0; i < 8; i++) begin
            apply(ta[i], tb[i], tc[i]);
            n_cmp++;
            if ({Cout, S} !== te[i]) begin
                n_bad++;
                $display("FAIL directed_%0d: A=%h B=%h Cin=%b got %h want %h",
                         i, ta[i], tb[i], tc[i], {Cout, S}, te[i]);
            end else begin
                $display("directed_%0d: A=%h B=%h Cin=%b -> Cout=%b S=%h",
                         i, ta[i], tb[i], tc[i], Cout, S);
            end
        end
    endtask

    task automatic test_registered;
        @(negedge clk);
        apply(8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h046) begin
            n_bad++;
            $display("FAIL reg_first: got %h want 046", {Cout_r, S_r});
        end
        @(negedge clk);
        apply(8'h0F, 8'h01, 1'b0);
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h046) begin
            n_bad++;
            $display("FAIL reg_hold_before_edge: got %h want 046", {Cout_r, S_r});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h010) begin
            n_bad++;
            $display("FAIL reg_after_edge: got %h want 010", {Cout_r, S_r});
        end
        $display("registered: Cout_r=%b S_r=%h", Cout_r, S_r);
    endtask

    task automatic test_midstream_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h000) begin
            n_bad++;
            $display("FAIL async_clear: got %h want 000", {Cout_r, S_r});
        end
        n_cmp++;
        if ({Cout, S} !== 9'h010) begin
            n_bad++;
            $display("FAIL comb_during_reset: got %h want 010", {Cout, S});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h000) begin
            n_bad++;
            $display("FAIL hold_in_reset: got %h want 000", {Cout_r, S_r});
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'hFF, 8'h01, 1'b0);
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h000) begin
            n_bad++;
            $display("FAIL no_capture_before_edge: got %h want 000", {Cout_r, S_r});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({Cout_r, S_r} !== 9'h100) begin
            n_bad++;
            $display("FAIL resume_capture: got %h want 100", {Cout_r, S_r});
        end
        $display("mid-stream reset: Cout_r=%b S_r=%h", Cout_r, S_r);
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            exp = 9'(a) + 9'(b) + 9'(c);
            apply(a, b, c);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({Cout_r, S_r} !== exp) begin
                n_bad++;
                $display("FAIL random_reg_%0d: A=%h B=%h Cin=%b got %h want %h",
                         i, a, b, c, {Cout_r, S_r}, exp);
            end
        end
        $display("random: 200 registered vectors checked");
    endtask

    task automatic test_exhaustive;
        logic [8:0] exp;
        for (int v = 0; v < (1 << 17); v++) begin
            apply(v[16:9], v[8:1], v[0]);
            exp = 9'(v[16:9]) + 9'(v[8:1]) + 9'(v[0]);
            n_cmp++;
            if ({Cout, S} !== exp) begin
                n_bad++;
                $display("FAIL sweep: A=%h B=%h Cin=%b got %h want %h",
                         v[16:9], v[8:1], v[0], {Cout, S}, exp);
            end
        end
        $display("exhaustive: 131072 combinational vectors checked");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_registered();
        test_midstream_reset();
        test_random();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
